tx_frontend: RTL and testbench
==============================

Name: tx_frontend

Overview:
- UART transmit frontend: serialises one character per handshake onto `uart_tx_o`.
- Frame format, LSB first: start bit, data bits, optional parity bit, stop bits.
- Uses the same control-register fields as the receive frontend: clock divider, data size, parity, stop bits.
- Sits between the TX FIFO / register interface and the UART pin. It is the counterpart of rx_frontend.

Parameters:
- None. Widths are fixed by the control register map.

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  reset, synchronous, active-high
- cr_clk_div_i  input  16  clock cycles per bit period; 0 is treated as 1
- cr_ds_i  input  1  data size: 0 = 8 bits, 1 = 7 bits
- cr_p_i  input  2  parity: 00 none, 01 even, 10 odd, 11 none (reserved)
- cr_s_i  input  1  stop bits: 0 = one, 1 = two
- data_i  input  8  character to send; bit 7 is ignored when cr_ds_i=1
- input_valid_i  input  1  data_i is valid
- input_ready_o  output  1  block accepts data_i this cycle
- uart_tx_o  output  1  serial line; idle high
- busy_o  output  1  frame in progress

Behaviour:
- Reset values: uart_tx_o=1, input_ready_o=1, busy_o=0, state_q=IDLE, all counters 0.
- Handshake:
  - A transfer occurs when input_valid_i && input_ready_o on a rising edge.
  - data_i, cr_clk_div_i, cr_ds_i, cr_p_i and cr_s_i are latched on that edge.
  - Control-register changes during a frame have no effect until the next accept.
- State machine (state_q, enum in package): IDLE, START, DATA, PARITY, STOP.
  - IDLE: input_ready_o=1, uart_tx_o=1. Accept moves to START.
  - START: uart_tx_o=0 for one bit period, then DATA.
  - DATA: uart_tx_o = shift register bit 0, shifted right each bit period. After 8 bits (or 7 if latched ds=1), go to PARITY if parity is enabled, else STOP.
  - PARITY: even mode sends XOR of the sent data bits; odd mode sends its inverse. Lasts one bit period.
  - STOP: uart_tx_o=1 for 1 or 2 bit periods, then IDLE.
- Output timing:
  - uart_tx_o is registered.
  - The start bit appears the cycle after the accept edge.
  - Every bit is held exactly max(div,1) cycles.
- Frame length in cycles: div × (1 + N + P + S), with N = 7 or 8, P = 0 or 1, S = 1 or 2.
- input_ready_o:
  - Is 0 from the cycle after accept until state_q returns to IDLE.
  - Rises on the first cycle after the last stop bit ends.
  - Is purely a function of state, with no combinational path from input_valid_i.
- busy_o = (state_q != IDLE).
- Bit-period counter: 16-bit down-counter, loaded with div-1 on each bit start; advances state or bit on reaching 0. No wrap beyond the loaded value.
- Bit counter: 3 bits plus a terminal flag; 7-bit mode terminates at 7.
- Reset mid-frame: the line returns high on the next edge and the in-progress frame is discarded. No partial stop bit is sent.
- input_valid_i while not ready: ignored, and data_i is not sampled.
- state_q must remain a named register so the bench can expose it for inspection.

Optional Feature:
- Macro: WBUART_TX_HOLD_BUFFER_EN.
- Defined:
  - Adds a one-entry holding register (data plus latched config).
  - input_ready_o = hold buffer empty, so a transfer can be accepted during an active frame.
  - At the end of the last stop bit, a full buffer loads directly into START with no idle cycle, giving back-to-back frames.
  - Accepting in IDLE with the buffer empty bypasses the buffer and keeps the same start-bit latency as without the feature.
  - Reset clears the buffer.
- Undefined: single-character behaviour exactly as described above, with at least one idle-high cycle between frames.

Decomposition:
- Shared package wbuart_pkg:
  - tx_state_t enum (IDLE, START, DATA, PARITY, STOP).
  - Parity encodings PARITY_NONE, PARITY_EVEN, PARITY_ODD.
  - DS_8BIT, DS_7BIT.
  - CLK_DIV_W=16.
- One sub-module: baud_counter.
  - Loadable 16-bit down-counter with tick output.
  - Reusable by rx_frontend.

Test Plan:
- div=4, 8N1, data 0x55:
  - Start bit 0 appears the cycle after accept, then 1,0,1,0,1,0,1,0, then stop 1; each bit lasts 4 cycles, 40 cycles total.
  - input_ready_o returns to 1 on cycle 41.
- div=3, ds=1, even parity, 2 stop bits, data 0xA5:
  - Sends 7 bits 1,0,1,0,0,1,0, then parity 1, then 1,1.
  - Bit 7 is ignored; 33 cycles total.
- div=2, odd parity, data 0x00 -> parity bit 1; div=0 -> every bit lasts 1 cycle.
- Change cr_clk_div_i from 4 to 8 mid-frame -> the current frame keeps 4-cycle bits; the next frame uses 8.
- Assert rst_i during the DATA state -> the cycle after, uart_tx_o=1, input_ready_o=1, busy_o=0, and state_q=IDLE.
- With WBUART_TX_HOLD_BUFFER_EN, div=2, 8N1, send 0x01 then 0x02 held valid:
  - The second start bit immediately follows the first stop bit with no idle cycle.
  - Without the macro, at least 1 high cycle separates the frames.

Source files
------------

// File: rtl/wbuart_pkg.sv
// Shared UART definitions: transmit state encoding, control-register field
// encodings, the latched per-frame configuration payload and small helpers.
package wbuart_pkg;

    localparam int unsigned CLK_DIV_W = 16;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned BIT_CNT_W = 3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic [1:0] PARITY_NONE = 2'b00;
    localparam logic [1:0] PARITY_EVEN = 2'b01;
    localparam logic [1:0] PARITY_ODD  = 2'b10;

    localparam logic DS_8BIT = 1'b0;
    localparam logic DS_7BIT = 1'b1;

    // One character plus the control fields that govern its frame
    typedef struct packed {
        logic [CLK_DIV_W-1:0] div;
        logic                 ds;
        logic [1:0]           p;
        logic                 s;
        logic [DATA_W-1:0]    data;
    } tx_cfg_t;

    // Reload value for the bit-period counter; a divider of 0 behaves as 1
    function automatic logic [CLK_DIV_W-1:0] div_minus_one(input logic [CLK_DIV_W-1:0] div);
        return (div == '0) ? '0 : div - CLK_DIV_W'(1);
    endfunction

    // Reserved encoding 11 behaves as no parity
    function automatic logic parity_enabled(input logic [1:0] p);
        return (p == PARITY_EVEN) || (p == PARITY_ODD);
    endfunction

    // Parity over the bits actually sent; bit 7 excluded in 7-bit mode
    function automatic logic parity_bit(input logic [DATA_W-1:0] data, input logic ds,
                                        input logic [1:0] p);
        logic x;
        x = (ds == DS_7BIT) ? ^data[6:0] : ^data;
        return (p == PARITY_ODD) ? ~x : x;
    endfunction

endpackage

// File: rtl/baud_counter.sv
// Loadable bit-period down-counter shared by the UART frontends.
// Ports: clk, rst (sync, active-high), load / load_value restart the period,
// tick_c is high while the count sits at zero (last cycle of the period).
module baud_counter
    import wbuart_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [CLK_DIV_W-1:0] load_value,
    output logic                 tick_c
);

    logic [CLK_DIV_W-1:0] count_q;

    // Counts down to zero and holds there; never wraps
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_value;
        end else if (count_q != '0) begin
            count_q <= count_q - CLK_DIV_W'(1);
        end
    end

    assign tick_c = (count_q == '0);

endmodule

// File: rtl/tx_frontend.sv
// UART transmit frontend: accepts one character per valid/ready handshake and
// serialises it LSB first as start, 7/8 data, optional parity, 1/2 stop bits.
// Ports: clk_i, rst_i (sync, active-high), cr_clk_div_i/cr_ds_i/cr_p_i/cr_s_i
// control fields latched at accept, data_i/input_valid_i/input_ready_o
// handshake, uart_tx_o serial line (idle high), busy_o frame in progress.
// Build option WBUART_TX_HOLD_BUFFER_EN adds a one-entry holding register so a
// second character can be accepted mid-frame and sent back-to-back.
module tx_frontend
    import wbuart_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [CLK_DIV_W-1:0] cr_clk_div_i,
    input  logic                 cr_ds_i,
    input  logic [1:0]           cr_p_i,
    input  logic                 cr_s_i,
    input  logic [DATA_W-1:0]    data_i,
    input  logic                 input_valid_i,
    output logic                 input_ready_o,
    output logic                 uart_tx_o,
    output logic                 busy_o
);

    tx_state_t            state_q, state_d;
    logic                 tx_q, tx_d;
    logic                 ready_q, ready_d;
    logic                 busy_q;
    logic [DATA_W-1:0]    shreg_q, shreg_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic [CLK_DIV_W-1:0] div_m1_q;
    logic                 ds_q;
    logic [1:0]           p_q;
    logic                 s_q;
    logic                 par_q;

    logic                 accept_c;
    logic                 tick_c;
    logic                 bit_last_c;
    logic                 start_c;
    logic                 load_c;
    logic [CLK_DIV_W-1:0] load_value_c;
    logic                 hold_full_c;
    tx_cfg_t              cfg_in_c;
    tx_cfg_t              cfg_sel_c;

    assign accept_c = input_valid_i && ready_q;
    assign cfg_in_c = '{div: cr_clk_div_i, ds: cr_ds_i, p: cr_p_i, s: cr_s_i, data: data_i};

    // Terminal flag of the bit counter: index 6 in 7-bit mode, 7 otherwise
    assign bit_last_c = (bit_cnt_q == ((ds_q == DS_7BIT) ? BIT_CNT_W'(6) : BIT_CNT_W'(7)));

`ifdef WBUART_TX_HOLD_BUFFER_EN
    tx_cfg_t hold_q;
    logic    hold_valid_q, hold_valid_d;

    // Accepts not consumed by a frame start this cycle park in the buffer
    always_comb begin
        hold_valid_d = hold_valid_q;
        if (start_c && hold_valid_q) begin
            hold_valid_d = 1'b0;
        end
        if (accept_c && !start_c) begin
            hold_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hold_valid_q <= 1'b0;
            hold_q       <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            if (accept_c && !start_c) begin
                hold_q <= cfg_in_c;
            end
        end
    end

    assign hold_full_c = hold_valid_q;
    assign cfg_sel_c   = hold_valid_q ? hold_q : cfg_in_c;
    assign ready_d     = !hold_valid_d;
`else
    assign hold_full_c = 1'b0;
    assign cfg_sel_c   = cfg_in_c;
    assign ready_d     = (state_d == IDLE);
`endif

    baud_counter u_baud_counter (
        .clk        (clk_i),
        .rst        (rst_i),
        .load       (load_c),
        .load_value (load_value_c),
        .tick_c     (tick_c)
    );

    // Next state and next line level; tx_d is the level for the coming cycle
    always_comb begin
        state_d      = state_q;
        tx_d         = tx_q;
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        stop_cnt_d   = stop_cnt_q;
        start_c      = 1'b0;
        load_c       = 1'b0;
        load_value_c = div_m1_q;

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (accept_c || hold_full_c) begin
                    start_c = 1'b1;
                end
            end
            START: begin
                if (tick_c) begin
                    state_d   = DATA;
                    tx_d      = shreg_q[0];
                    bit_cnt_d = '0;
                    load_c    = 1'b1;
                end
            end
            DATA: begin
                if (tick_c) begin
                    load_c = 1'b1;
                    if (!bit_last_c) begin
                        shreg_d   = shreg_q >> 1;
                        tx_d      = shreg_q[1];
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end else if (parity_enabled(p_q)) begin
                        state_d = PARITY;
                        tx_d    = par_q;
                    end else begin
                        state_d    = STOP;
                        tx_d       = 1'b1;
                        stop_cnt_d = 1'b0;
                    end
                end
            end
            PARITY: begin
                if (tick_c) begin
                    state_d    = STOP;
                    tx_d       = 1'b1;
                    stop_cnt_d = 1'b0;
                    load_c     = 1'b1;
                end
            end
            STOP: begin
                if (tick_c) begin
                    if (s_q && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                        load_c     = 1'b1;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                        // Only reachable with the holding register present
                        if (hold_full_c || accept_c) begin
                            start_c = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // New frame: start bit goes out on the very next cycle
        if (start_c) begin
            state_d      = START;
            tx_d         = 1'b0;
            load_c       = 1'b1;
            load_value_c = div_minus_one(cfg_sel_c.div);
            bit_cnt_d    = '0;
            stop_cnt_d   = 1'b0;
            shreg_d      = (cfg_sel_c.ds == DS_7BIT) ? {1'b0, cfg_sel_c.data[6:0]}
                                                     : cfg_sel_c.data;
        end
    end

    // State, line and per-frame configuration registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            tx_q       <= 1'b1;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            div_m1_q   <= '0;
            ds_q       <= DS_8BIT;
            p_q        <= PARITY_NONE;
            s_q        <= 1'b0;
            par_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            ready_q    <= ready_d;
            busy_q     <= (state_d != IDLE);
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            if (start_c) begin
                div_m1_q <= div_minus_one(cfg_sel_c.div);
                ds_q     <= cfg_sel_c.ds;
                p_q      <= cfg_sel_c.p;
                s_q      <= cfg_sel_c.s;
                par_q    <= parity_bit(cfg_sel_c.data, cfg_sel_c.ds, cfg_sel_c.p);
            end
        end
    end

    assign uart_tx_o     = tx_q;
    assign input_ready_o = ready_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_tx_frontend.sv
// Bench for tx_frontend: each accepted character pushes its expected per-cycle
// line levels into a queue; a negedge monitor pops and compares them, and
// checks the idle line between frames.
module tb_tx_frontend;
    import wbuart_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [15:0] cr_clk_div_i;
    logic        cr_ds_i;
    logic [1:0]  cr_p_i;
    logic        cr_s_i;
    logic [7:0]  data_i;
    logic        input_valid_i;
    logic        input_ready_o;
    logic        uart_tx_o;
    logic        busy_o;

    tx_frontend dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .cr_clk_div_i  (cr_clk_div_i),
        .cr_ds_i       (cr_ds_i),
        .cr_p_i        (cr_p_i),
        .cr_s_i        (cr_s_i),
        .data_i        (data_i),
        .input_valid_i (input_valid_i),
        .input_ready_o (input_ready_o),
        .uart_tx_o     (uart_tx_o),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        bit tx;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec     = 0;
    int   n_err     = 0;
    int   cyc       = 0;
    int   line_free = 0;
    bit   mon_en    = 1'b0;
    bit   m_tx;
    bit   m_busy;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected line levels of one frame starting at cycle 'start'
    task automatic push_frame(input int div, input bit ds, input bit [1:0] p, input bit s,
                              input bit [7:0] d, input int start);
        bit bits[$];
        int per;
        int nb;
        int c;
        bit par;
        per = (div == 0) ? 1 : div;
        nb  = ds ? 7 : 8;
        bits.push_back(1'b0);
        par = 1'b0;
        for (int i = 0; i < nb; i++) begin
            bits.push_back(d[i]);
            par = par ^ d[i];
        end
        if (p == 2'b01) bits.push_back(par);
        if (p == 2'b10) bits.push_back(~par);
        bits.push_back(1'b1);
        if (s) bits.push_back(1'b1);
        c = start;
        foreach (bits[i]) begin
            for (int k = 0; k < per; k++) begin
                exp_q.push_back('{cyc: c, tx: bits[i]});
                c++;
            end
        end
        line_free = c - 1;
    endtask

    // Called at a negedge; returns at the negedge after the accept edge
    task automatic send_frame(input int div, input bit ds, input bit [1:0] p, input bit s,
                              input bit [7:0] d, input bit keep);
        int n;
        int start;
        cr_clk_div_i  = 16'(div);
        cr_ds_i       = ds;
        cr_p_i        = p;
        cr_s_i        = s;
        data_i        = d;
        input_valid_i = 1'b1;
        n = 0;
        while (!input_ready_o && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!input_ready_o) begin
            check_val("accept_timeout", 32'(input_ready_o), 32'd1);
            input_valid_i = 1'b0;
            return;
        end
        @(posedge clk);
        start = (cyc + 1 > line_free + 1) ? cyc + 1 : line_free + 1;
        push_frame(div, ds, p, s, d, start);
        @(negedge clk);
        if (!keep) input_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_val("drain", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    // Monitor: scheduled frame bits, or idle-high line between frames
    always @(negedge clk) begin
        cyc++;
        if (mon_en) begin
            m_tx   = 1'b1;
            m_busy = 1'b0;
            if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                m_tx   = exp_q[0].tx;
                m_busy = 1'b1;
                void'(exp_q.pop_front());
            end
            check_val($sformatf("tx@%0d", cyc), 32'(uart_tx_o), 32'(m_tx));
            check_val($sformatf("busy@%0d", cyc), 32'(busy_o), 32'(m_busy));
`ifndef WBUART_TX_HOLD_BUFFER_EN
            check_val($sformatf("ready@%0d", cyc), 32'(input_ready_o), 32'(!m_busy));
`endif
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_i         = 1'b1;
        cr_clk_div_i  = 16'd0;
        cr_ds_i       = 1'b0;
        cr_p_i        = 2'b00;
        cr_s_i        = 1'b0;
        data_i        = 8'h00;
        input_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        check_val("rst_tx", 32'(uart_tx_o), 32'd1);
        check_val("rst_ready", 32'(input_ready_o), 32'd1);
        check_val("rst_busy", 32'(busy_o), 32'd0);
        check_val("rst_state", 32'(dut.state_q), 32'(IDLE));
        mon_en = 1'b1;
        @(negedge clk);

        // 8N1, div 4
        send_frame(4, 1'b0, 2'b00, 1'b0, 8'h55, 1'b0);
        drain();
        // 7E2, div 3, bit 7 ignored
        send_frame(3, 1'b1, 2'b01, 1'b1, 8'hA5, 1'b0);
        drain();
        // 8O1, div 2, zero data gives parity 1
        send_frame(2, 1'b0, 2'b10, 1'b0, 8'h00, 1'b0);
        drain();
        // div 0 behaves as 1, odd parity, two stops
        send_frame(0, 1'b0, 2'b10, 1'b1, 8'h3C, 1'b0);
        drain();
        // reserved parity encoding sends no parity bit
        send_frame(1, 1'b0, 2'b11, 1'b0, 8'hE1, 1'b0);
        drain();

        // divider changed mid-frame only affects the next frame
        send_frame(4, 1'b0, 2'b00, 1'b0, 8'h96, 1'b0);
`ifndef WBUART_TX_HOLD_BUFFER_EN
        input_valid_i = 1'b1;
        data_i        = 8'hFF;
        repeat (3) @(negedge clk);
        input_valid_i = 1'b0;
`endif
        cr_clk_div_i = 16'd8;
        drain();
        send_frame(8, 1'b0, 2'b00, 1'b0, 8'h3C, 1'b0);
        drain();

        // two characters with valid held high
        send_frame(2, 1'b0, 2'b00, 1'b0, 8'h01, 1'b1);
        send_frame(2, 1'b0, 2'b00, 1'b0, 8'h02, 1'b0);
        drain();

        // reset during the data bits discards the frame
        send_frame(4, 1'b0, 2'b00, 1'b0, 8'hC3, 1'b0);
        repeat (12) @(negedge clk);
        mon_en = 1'b0;
        exp_q.delete();
        line_free = 0;
        rst_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_val("midrst_tx", 32'(uart_tx_o), 32'd1);
        check_val("midrst_ready", 32'(input_ready_o), 32'd1);
        check_val("midrst_busy", 32'(busy_o), 32'd0);
        check_val("midrst_state", 32'(dut.state_q), 32'(IDLE));
        rst_i = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;
        @(negedge clk);
        send_frame(3, 1'b0, 2'b01, 1'b0, 8'h5A, 1'b0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
